// File: rtl/minterm_extractor_if.sv
// Minterm stream channel of the truth-table analyser: one index per found
// minterm, transferred on the clock edge where m_valid and m_ready are both high.
interface minterm_extractor_if #(
    parameter int N_VARS = 4
) ();
    logic              m_valid;
    logic [N_VARS-1:0] m_index;
    logic              m_ready;

    // Producer side (the analyser)
    modport master (
        output m_valid,
        output m_index,
        input  m_ready
    );

    // Consumer side
    modport slave (
        input  m_valid,
        input  m_index,
        output m_ready
    );
endinterface

// File: rtl/minterm_extractor.sv
// Sequential truth-table analyser. Walks every input vector of an external
// N_VARS-input combinational function, holds each vector for SETTLE cycles,
// samples the function output and builds the minterm mask and count. Every
// minterm index is offered on the stream channel before the sweep moves on,
// so indices leave in strictly ascending order.
module minterm_extractor #(
    parameter int N_VARS = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_VARS-1:0]    vec,
    input  logic                 s_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_VARS-1:0] mask,
    output logic [N_VARS:0]      count,
    minterm_extractor_if.master  m_if
);

    localparam int N_MT  = 2**N_VARS;
    // SETTLE is limited to 1..15, so four bits always hold the settle count.
    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [N_VARS-1:0] VEC_ONE   = N_VARS'(1);
    localparam logic [N_VARS-1:0] VEC_LAST  = '1;
    localparam logic [N_VARS:0]   COUNT_ONE = (N_VARS+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_EMIT,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [N_VARS-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_MT-1:0]     mask_q, mask_d;
    logic [N_VARS:0]     count_q, count_d;
    logic                m_valid_q, m_valid_d;
    logic [N_VARS-1:0]   m_index_q, m_index_d;

    // State and datapath registers; reset aborts any sweep without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            vec_q     <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            m_index_q <= '0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            count_q   <= count_d;
            m_valid_q <= m_valid_d;
            m_index_q <= m_index_d;
        end
    end

    // Sweep sequencing: settle, sample, optionally emit, then step or finish.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        count_d   = count_q;
        m_valid_d = m_valid_q;
        m_index_d = m_index_q;

        case (state_q)
            S_IDLE: begin
                // Results of the previous sweep stay visible until a new start.
                if (start) begin
                    mask_d  = '0;
                    count_d = '0;
                    vec_d   = '0;
                    cnt_d   = SETTLE_LD;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                if (cnt_q == CNT_ONE) begin
                    // Last settle cycle: the function output is trusted now.
                    mask_d[vec_q] = s_in;
                    cnt_d         = cnt_q - CNT_ONE;
                    if (s_in) begin
                        count_d   = count_q + COUNT_ONE;
                        m_valid_d = 1'b1;
                        m_index_d = vec_q;
                        state_d   = S_EMIT;
                    end else if (vec_q == VEC_LAST) begin
                        // vec parks at all-ones; it never wraps back to zero.
                        state_d = S_FIN;
                    end else begin
                        vec_d = vec_q + VEC_ONE;
                        cnt_d = SETTLE_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_EMIT: begin
                // vec is frozen here so the sweep resumes right after this index.
                if (m_valid_q && m_if.m_ready) begin
                    m_valid_d = 1'b0;
                    if (vec_q == VEC_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        vec_d   = vec_q + VEC_ONE;
                        cnt_d   = SETTLE_LD;
                        state_d = S_HOLD;
                    end
                end
            end

            S_FIN: begin
                // Single-cycle completion state; start is not looked at here.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign vec          = vec_q;
    assign mask         = mask_q;
    assign count        = count_q;
    assign busy         = (state_q == S_HOLD) || (state_q == S_EMIT);
    assign done         = (state_q == S_FIN);
    assign m_if.m_valid = m_valid_q;
    assign m_if.m_index = m_index_q;

endmodule

// File: tb/tb_minterm_extractor.sv
// Bench for minterm_extractor: two instances (SETTLE=1 and SETTLE=3) driven
// with truth tables; expected minterm streams and sweep results are queued
// when a sweep is launched and consumed by an independent monitor.
module tb_minterm_extractor;

    localparam int NV = 4;
    localparam int NM = 16;

    typedef struct {
        logic [NM-1:0] tt;
        int            start_edge;
        int            exp_stalls;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_s [2];
    logic [NM-1:0] tt_s    [2];
    logic [NV-1:0] vec_s   [2];
    logic          s_in_s  [2];
    logic          busy_s  [2];
    logic          done_s  [2];
    logic [NM-1:0] mask_s  [2];
    logic [NV:0]   count_s [2];
    logic          mval_s  [2];
    logic [NV-1:0] midx_s  [2];
    logic          ready_s [2];

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    res_t res_q [2][$];
    int   exp_q [2][$];
    int   rmode      [2] = '{0, 0};
    int   held       [2] = '{0, 0};
    bit   run_active [2] = '{0, 0};
    int   run_v      [2] = '{0, 0};
    int   run_len    [2] = '{0, 0};
    int   run_stall  [2] = '{0, 0};
    int   stall_obs  [2] = '{0, 0};
    int   v5cyc      [2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int S = (g == 0) ? 1 : 3;
        minterm_extractor_if #(.N_VARS(NV)) mif ();
        minterm_extractor #(.N_VARS(NV), .SETTLE(S)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_s[g]),
            .vec   (vec_s[g]),
            .s_in  (s_in_s[g]),
            .busy  (busy_s[g]),
            .done  (done_s[g]),
            .mask  (mask_s[g]),
            .count (count_s[g]),
            .m_if  (mif.master)
        );
        assign mif.m_ready = ready_s[g];
        assign mval_s[g]   = mif.m_valid;
        assign midx_s[g]   = mif.m_index;
        assign s_in_s[g]   = tt_s[g][vec_s[g]];
    end

    function automatic int settle_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic chk(input int ln, input bit ok, input string nm,
                       input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL lane%0d %s: got %0d, expected %0d", ln, nm, act, exp);
    endtask

    task automatic end_run(input int g);
        int e;
        e = settle_of(g) + (tt_s[g][run_v[g]] ? 1 + run_stall[g] : 0);
        chk(g, run_len[g] == e, "vec_hold_cycles", run_len[g], e);
    endtask

    task automatic mon_step(input int g);
        res_t r;
        int   stalls;
        int   ecyc;
        bit   stall_now;
        if (!rst_n) begin
            exp_q[g].delete();
            res_q[g].delete();
            run_active[g] = 1'b0;
            stall_obs[g]  = 0;
            return;
        end
        stall_now = mval_s[g] && !ready_s[g];
        if (mval_s[g]) begin
            if (midx_s[g] == 5) v5cyc[g]++;
            if (exp_q[g].size() == 0) begin
                chk(g, 1'b0, "unexpected_m_valid", midx_s[g], -1);
            end else begin
                chk(g, midx_s[g] == exp_q[g][0], "m_index", midx_s[g], exp_q[g][0]);
                chk(g, vec_s[g] == exp_q[g][0], "vec_during_emit", vec_s[g], exp_q[g][0]);
                if (ready_s[g]) void'(exp_q[g].pop_front());
                else stall_obs[g]++;
            end
        end
        if (busy_s[g]) begin
            if (!run_active[g]) begin
                chk(g, vec_s[g] == 0, "first_vec", vec_s[g], 0);
                run_active[g] = 1'b1;
                run_v[g]      = int'(vec_s[g]);
                run_len[g]    = 1;
                run_stall[g]  = stall_now ? 1 : 0;
            end else if (int'(vec_s[g]) == run_v[g]) begin
                run_len[g]++;
                if (stall_now) run_stall[g]++;
            end else begin
                end_run(g);
                chk(g, int'(vec_s[g]) == run_v[g] + 1, "vec_step", vec_s[g], run_v[g] + 1);
                run_v[g]     = int'(vec_s[g]);
                run_len[g]   = 1;
                run_stall[g] = stall_now ? 1 : 0;
            end
        end else if (run_active[g]) begin
            end_run(g);
            run_active[g] = 1'b0;
        end
        if (done_s[g]) begin
            if (res_q[g].size() == 0) begin
                chk(g, 1'b0, "unexpected_done", 1, 0);
            end else begin
                r      = res_q[g].pop_front();
                stalls = (r.exp_stalls >= 0) ? r.exp_stalls : stall_obs[g];
                ecyc   = NM * settle_of(g) + $countones(r.tt) + stalls + 1;
                chk(g, mask_s[g] == r.tt, "mask", mask_s[g], r.tt);
                chk(g, count_s[g] == $countones(r.tt), "count", count_s[g], $countones(r.tt));
                chk(g, busy_s[g] == 1'b0, "busy_in_fin", busy_s[g], 0);
                chk(g, exp_q[g].size() == 0, "missing_minterms", exp_q[g].size(), 0);
                chk(g, (cyc - r.start_edge + 1) == ecyc, "done_cycle", cyc - r.start_edge + 1, ecyc);
                stall_obs[g] = 0;
            end
        end
    endtask

    task automatic ready_step(input int g);
        case (rmode[g])
            1: ready_s[g] = 1'($urandom_range(0, 1));
            2: begin
                if (mval_s[g] && midx_s[g] == 5) begin
                    held[g]++;
                    ready_s[g] = (held[g] >= 4);
                end else begin
                    held[g]    = 0;
                    ready_s[g] = 1'b1;
                end
            end
            default: ready_s[g] = 1'b1;
        endcase
    endtask

    // Monitor: evaluates both lanes away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) mon_step(g);
        end
    end

    // Consumer back-pressure, updated just after each active edge.
    initial begin
        ready_s[0] = 1'b1;
        ready_s[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) ready_step(g);
        end
    end

    task automatic begin_sweep(input int ln, input logic [NM-1:0] t, input int mode);
        res_t r;
        @(negedge clk);
        tt_s[ln]  = t;
        rmode[ln] = mode;
        for (int i = 0; i < NM; i++) if (t[i]) exp_q[ln].push_back(i);
        r.tt         = t;
        r.start_edge = cyc + 1;
        r.exp_stalls = (mode == 1) ? -1 : ((mode == 2 && t[5]) ? 3 : 0);
        res_q[ln].push_back(r);
        start_s[ln] = 1'b1;
        @(negedge clk);
        start_s[ln] = 1'b0;
    endtask

    task automatic wait_done(input int ln);
        int k;
        for (k = 0; k < 3000 && res_q[ln].size() != 0; k++) @(negedge clk);
        if (res_q[ln].size() != 0) begin
            chk(ln, 1'b0, "sweep_timeout", k, 0);
            res_q[ln].delete();
            exp_q[ln].delete();
        end
        @(negedge clk);
    endtask

    task automatic sweep(input int ln, input logic [NM-1:0] t, input int mode);
        begin_sweep(ln, t, mode);
        wait_done(ln);
    endtask

    task automatic chk_zero(input int g, input string pfx);
        chk(g, vec_s[g] == 0, {pfx, "_vec"}, vec_s[g], 0);
        chk(g, busy_s[g] == 0, {pfx, "_busy"}, busy_s[g], 0);
        chk(g, done_s[g] == 0, {pfx, "_done"}, done_s[g], 0);
        chk(g, mask_s[g] == 0, {pfx, "_mask"}, mask_s[g], 0);
        chk(g, count_s[g] == 0, {pfx, "_count"}, count_s[g], 0);
        chk(g, mval_s[g] == 0, {pfx, "_m_valid"}, mval_s[g], 0);
        chk(g, midx_s[g] == 0, {pfx, "_m_index"}, midx_s[g], 0);
    endtask

    // Stimulus: directed sweeps, random truth tables, start/reset disturbances.
    initial begin
        logic [NM-1:0] t;
        int            k;
        int            nd;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        tt_s[0]    = '0;
        tt_s[1]    = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) chk_zero(g, "reset");
        #3 rst_n = 1'b1;
        @(negedge clk);

        sweep(0, 16'h0E26, 0);
        repeat (3) @(negedge clk);
        chk(0, mask_s[0] == 16'h0E26, "mask_hold", mask_s[0], 16'h0E26);
        chk(0, count_s[0] == 6, "count_hold", count_s[0], 6);
        chk(0, vec_s[0] == 4'hF, "vec_park", vec_s[0], 15);
        chk(0, busy_s[0] == 0, "busy_idle", busy_s[0], 0);

        v5cyc[0] = 0;
        sweep(0, 16'h0E26, 2);
        chk(0, v5cyc[0] == 4, "index5_held_cycles", v5cyc[0], 4);

        sweep(0, 16'h0000, 0);
        sweep(0, 16'hFFFF, 0);
        sweep(1, 16'h8000, 0);

        repeat (6) begin
            t = 16'($urandom);
            sweep(0, t, 1);
        end
        repeat (2) begin
            t = 16'($urandom);
            sweep(1, t, 1);
        end

        t = 16'($urandom);
        begin_sweep(0, t, 0);
        repeat (6) @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_done(0);

        t = 16'($urandom);
        begin_sweep(0, t, 0);
        k = 0;
        while (vec_s[0] != 4'd7 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(0, vec_s[0] == 4'd7, "reach_vec7", vec_s[0], 7);
        #2 rst_n = 1'b0;
        #1 chk_zero(0, "async_reset");
        @(negedge clk);
        #3 rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_s[0]) nd++;
        end
        chk(0, nd == 0, "done_after_reset", nd, 0);

        t = 16'($urandom);
        sweep(0, t, 1);
        sweep(0, 16'h0E26, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/minterm_extractor.md
Name: minterm_extractor

Overview:
- Sequential truth-table analyser: the inverse of a sum-of-products realisation.
- Sweeps every input combination of an external N_VARS-input combinational function under test, samples its single output and records the result as a minterm mask and minterm count.
- Each minterm index is streamed out over a valid/ready channel as it is found.
- Used on-chip to derive SoP(m...) lists from combinational blocks and to cross-check simplified against canonical forms.

Parameters:
- N_VARS, 4, number of function inputs; vec[N_VARS-1] is x (MSB), vec[0] is z (LSB).
- SETTLE, 1, cycles each input vector is held before the output is sampled; legal range 1..15.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a sweep; accepted only in IDLE.
- vec  out  N_VARS  input vector driven to the function under test; registered.
- s_in  in  1  output of the function under test.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse at the end of a sweep.
- mask  out  2**N_VARS  bit i = function value at input i.
- count  out  N_VARS+1  number of minterms found.
- m_valid  out  1  minterm index available.
- m_index  out  N_VARS  minterm index.
- m_ready  in  1  consumer accepts m_index.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; vec=0, busy=0, done=0, mask=0, count=0, m_valid=0, m_index=0, settle counter=0. Reset mid-sweep aborts immediately; no done pulse.
- IDLE:
  - start=1 at an edge: clear mask and count, vec<=0, load settle counter with SETTLE, busy<=1, go to HOLD.
  - start has no effect in any other state.
- HOLD:
  - vec is held stable; the settle counter decrements each cycle.
  - On the edge ending the SETTLE-th HOLD cycle, s_in is sampled, mask[vec]<=s_in, and the state advances:
    - s_in=1: count<=count+1, m_valid<=1, m_index<=vec, go to EMIT.
    - s_in=0 and vec != all-ones: vec<=vec+1, reload the counter, stay in HOLD.
    - s_in=0 and vec == all-ones: go to FIN.
- EMIT:
  - m_valid, m_index and vec are held stable until the edge where m_valid and m_ready are both 1.
  - On that edge: m_valid<=0. Then vec<=vec+1, reload the counter and go to HOLD; or, if vec == all-ones, go to FIN.
  - m_ready=1 throughout gives one EMIT cycle per minterm.
  - m_ready is ignored when m_valid=0.
- FIN: done=1 and busy=0 for exactly this cycle; next state is IDLE. start in the FIN cycle is ignored.
- Holding behaviour:
  - mask and count hold their final values until the next accepted start.
  - vec stays at all-ones after the sweep ends.
- Ordering: indices are emitted in strictly ascending order, each exactly once.
- Width rules:
  - count saturates naturally at 2**N_VARS, which fits in N_VARS+1 bits.
  - vec is never incremented past all-ones; there is no wrap-around.
- Timing, with m_ready held at 1:
  - The start edge is edge 0.
  - done is high in cycle 2**N_VARS*SETTLE + count + 1.

Test Plan:
- Minterms {1,2,5,9,10,11}, SETTLE=1, m_ready=1 → m_index stream 1,2,5,9,10,11; mask=16'h0E26; count=6; done high in cycle 23.
- Same function, m_ready held 0 for 3 cycles after m_valid rises with m_index=5 → m_index and vec stay at 5 (0101) for 4 cycles; final mask=16'h0E26; done in cycle 26.
- Constant-0 function → m_valid never rises; mask=0; count=0; done in cycle 17. Constant-1 function → mask=16'hFFFF; count=16; done in cycle 33.
- SETTLE=3, minterm {15} only → vec changes every 3 cycles; single m_index=15; mask=16'h8000; count=1.
- start pulsed mid-sweep → ignored. rst_n low at vec=7 → all outputs 0 asynchronously, before the next clock edge, and no done pulse. A new start after reset completes a full correct sweep.
